mem_port_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory between the pipeline fetch stage (IF) and
//  the load/store stage (LS). Arbitrates, drives the memory port, registers read data, and returns
//  one-cycle acks. Sits between the pipeline and memory; the pipeline stalls a stage while its req
//  is high and no ack has arrived.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the IF/LS memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_LS = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates the unified memory port between fetch (IF) and load/store (LS)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  localparam int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ack,
  output logic [31:0] o_if_rdata,
  input  logic        i_ls_req,
  input  logic        i_ls_wren,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_bmask,
  output logic        o_ls_ack,
  output logic [31:0] o_ls_rdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  output logic        o_mem_wren,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_e       state, state_n;
  arb_owner_e       owner, owner_n;
  logic [CNT_W-1:0] starve_cnt, starve_n;
  logic [31:0]      if_rdata_q, ls_rdata_q;
  logic [31:0]      addr_q, wdata_q;
  logic             wren_c;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      starve_cnt <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      starve_cnt <= starve_n;
      if (state == GNT_IF) if_rdata_q <= i_mem_rdata;
      if (state == GNT_LS) ls_rdata_q <= i_mem_rdata;
      // Remember the last driven address/data so the port holds steady outside grants
      if (state == GNT_IF || state == GNT_LS) begin
        addr_q  <= o_mem_addr;
        wdata_q <= o_mem_wdata;
      end
    end
  end

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    starve_n = starve_cnt;
    case (state)
      IDLE: begin
        // LS normally wins a tie; IF is forced through once it has been passed over enough times
        if (i_if_req && (!i_ls_req || starve_cnt == LIMIT_C)) begin
          state_n  = GNT_IF;
          owner_n  = OWN_IF;
          starve_n = '0;
        end else if (i_ls_req) begin
          state_n = GNT_LS;
          owner_n = OWN_LS;
          if (i_if_req && starve_cnt < LIMIT_C) starve_n = starve_cnt + 1'b1;
        end
      end
      GNT_IF:  state_n = RESP;
      GNT_LS:  state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    o_mem_addr  = addr_q;
    o_mem_wdata = wdata_q;
    o_mem_bmask = 4'b0000;
    wren_c      = 1'b0;
    case (state)
      GNT_IF: o_mem_addr = i_if_addr;
      GNT_LS: begin
        o_mem_addr  = i_ls_addr;
        o_mem_wdata = i_ls_wdata;
        if (i_ls_wren) begin
          o_mem_bmask = i_ls_bmask;
          wren_c      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_mem_wren = wren_c & ~i_reset;
  assign o_if_ack   = (state == RESP) && (owner == OWN_IF);
  assign o_ls_ack   = (state == RESP) && (owner == OWN_LS);
  assign o_if_rdata = if_rdata_q;
  assign o_ls_rdata = ls_rdata_q;
  assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter against a small word memory
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_wren = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [3:0]  ls_bmask = '0;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_bmask;
  logic        mem_wren;
  logic        busy;

  mem_port_arbiter dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_ack    (if_ack),
    .o_if_rdata  (if_rdata),
    .i_ls_req    (ls_req),
    .i_ls_wren   (ls_wren),
    .i_ls_addr   (ls_addr),
    .i_ls_wdata  (ls_wdata),
    .i_ls_bmask  (ls_bmask),
    .o_ls_ack    (ls_ack),
    .o_ls_rdata  (ls_rdata),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_bmask (mem_bmask),
    .o_mem_wren  (mem_wren),
    .i_mem_rdata (mem_rdata),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_ls;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          wr_count = 0;
  logic [3:0]  last_bmask = '0;
  logic [31:0] mem [0:1023];

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (mem_bmask[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      wr_count   <= wr_count + 1;
      last_bmask <= mem_bmask;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && (if_ack || ls_ack)) begin
      chk("single_ack", {31'b0, if_ack & ls_ack}, 32'd0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got if_ack=%b ls_ack=%b expected none (cycle %0d)", if_ack, ls_ack, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("ack_port_is_ls", {31'b0, ls_ack}, {31'b0, e.is_ls});
        if (e.chk_data) chk("ack_rdata", e.is_ls ? ls_rdata : if_rdata, e.data);
        if (e.cyc >= 0) chk("ack_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_ack(input bit is_ls, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (is_ls ? ls_ack : if_ack) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no ack expected ack within 20 cycles", name);
      sb_q.delete();
    end
  endtask

  // Called at posedge+1 with the arbiter idle; returns at posedge+1 with it idle again
  task automatic ls_access(input logic [31:0] a, input bit w, input logic [31:0] wd,
                           input logic [3:0] bm, input bit cd, input logic [31:0] ed);
    sb_q.push_back('{1'b1, cd, ed, cyc + 2});
    ls_addr = a; ls_wren = w; ls_wdata = wd; ls_bmask = bm; ls_req = 1'b1;
    wait_ack(1'b1, "ls");
    @(posedge clk); #1;
    ls_req = 1'b0; ls_wren = 1'b0;
  endtask

  task automatic if_access(input logic [31:0] a, input logic [31:0] ed);
    sb_q.push_back('{1'b0, 1'b1, ed, cyc + 2});
    if_addr = a; if_req = 1'b1;
    wait_ack(1'b0, "if");
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    mem[16] <= 32'hDEADBEEF;   // 0x40
    mem[4]  <= 32'h00500093;   // 0x10
    mem[8]  <= 32'h11111111;   // 0x20
    mem[9]  <= 32'h22222222;   // 0x24
    mem[32] <= 32'hCAFE0001;   // 0x80
    mem[48] <= 32'hBEEF0002;   // 0xC0
  end

  initial begin
    int c;
    int wr0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_ack", {31'b0, if_ack}, 32'd0);
    chk("rst_ls_ack", {31'b0, ls_ack}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_wren", {31'b0, mem_wren}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // reset in the middle of a granted LS load
    ls_access(32'h40, 1'b0, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF);
    chk("ls_rdata_hold", ls_rdata, 32'hDEADBEEF);
    ls_addr = 32'h40; ls_wren = 1'b0; ls_req = 1'b1;
    @(posedge clk); #1;
    chk("busy_in_gnt", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    ls_req = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_ls_rdata", ls_rdata, 32'd0);
    chk("midrst_ls_ack", {31'b0, ls_ack}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("postrst_busy", {31'b0, busy}, 32'd0);

    // IF-only fetch with latency check
    if_access(32'h10, 32'h00500093);

    // byte-masked store then readback
    wr0 = wr_count;
    ls_access(32'h100, 1'b1, 32'hAABBCCDD, 4'b0011, 1'b0, 32'h0);
    chk("store_write_count", wr_count - wr0, 32'd1);
    chk("store_bmask", {28'b0, last_bmask}, {28'b0, 4'b0011});
    ls_access(32'h100, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0000CCDD);

    // IF held across its ack with a new address for the follow-on fetch
    c = cyc;
    sb_q.push_back('{1'b0, 1'b1, 32'h11111111, c + 2});
    sb_q.push_back('{1'b0, 1'b1, 32'h22222222, c + 5});
    if_addr = 32'h20; if_req = 1'b1;
    wait_ack(1'b0, "if_back2back_a");
    @(posedge clk); #1;
    if_addr = 32'h24;
    wait_ack(1'b0, "if_back2back_b");
    @(posedge clk); #1;
    if_req = 1'b0;

    // both requesters held: LS x4 then forced IF, twice
    c = cyc;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) sb_q.push_back('{1'b0, 1'b1, 32'hCAFE0001, c + 2 + 3*k});
      else                  sb_q.push_back('{1'b1, 1'b1, 32'hBEEF0002, c + 2 + 3*k});
    end
    if_addr = 32'h80; if_req = 1'b1;
    ls_addr = 32'hC0; ls_wren = 1'b0; ls_req = 1'b1;
    for (int i = 0; i < 60 && sb_q.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL starve_timeout: got %0d acks outstanding expected 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0;

    // LS store whose req drops during its grant
    wr0 = wr_count;
    sb_q.push_back('{1'b1, 1'b0, 32'h0, cyc + 2});
    ls_addr = 32'h200; ls_wdata = 32'h12345678; ls_bmask = 4'b1111; ls_wren = 1'b1; ls_req = 1'b1;
    @(posedge clk); #1;
    ls_req = 1'b0;
    wait_ack(1'b1, "ls_drop");
    @(posedge clk); #1;
    ls_wren = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("drop_busy", {31'b0, busy}, 32'd0);
    chk("drop_write_count", wr_count - wr0, 32'd1);
    ls_access(32'h200, 1'b0, 32'h0, 4'h0, 1'b1, 32'h12345678);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
